// File: rtl/led_matrix_scanner_pkg.sv
//------------------------------------------------------------------------------
// Module      : screen_pkg
// Description : Shared definitions for the multiplexed LED-matrix scanner:
//               scan FSM state type, anti-ghosting blank length and the
//               helper that derives the bus idle level from the polarity.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package screen_pkg;

  // Cycles at the end of each row that are forced dark when the
  // SCREEN_BLANK_EN guard is compiled in.
  localparam int BLANK_CYCLES = 2;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_t;

  // Idle (unlit) level of a single row/column line for the given polarity.
  function automatic logic inactive_level(input int active_low);
    return (active_low != 0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/led_matrix_scanner_if.sv
//------------------------------------------------------------------------------
// Module      : led_matrix_scanner_if
// Description : Frame hand-off channel between the frame producer (master)
//               and the matrix scanner (slave). A frame moves on any clock
//               edge where frame_valid and frame_ready are both high.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface led_matrix_scanner_if #(
  parameter int ROWS = 8,
  parameter int COLS = 16
);

  logic [ROWS*COLS-1:0] frame_data;
  logic                 frame_valid;
  logic                 frame_ready;

  modport master (
    output frame_data,
    output frame_valid,
    input  frame_ready
  );

  modport slave (
    input  frame_data,
    input  frame_valid,
    output frame_ready
  );

endinterface

`default_nettype wire

// File: rtl/led_matrix_scanner_timer.sv
//------------------------------------------------------------------------------
// Module      : scan_timer
// Description : Row/dwell counters for the matrix scanner. Counts dwell
//               cycles within a row and steps through the rows while run is
//               high; run low clears both counters back to row 0, cycle 0.
//               Produces the frame-boundary strobe (last cycle of last row
//               while still running) and the frame-start strobe.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module scan_timer #(
  parameter int ROWS    = 8,
  parameter int DWELL   = 1024,
  parameter int ROW_W   = 3,
  parameter int DWELL_W = 10
) (
  input  wire logic               clk,
  input  wire logic               rst,
  input  wire logic               scanning,
  input  wire logic               run,
  output logic [DWELL_W-1:0]      dwell_cnt,
  output logic [ROW_W-1:0]        row_idx,
  output logic                    boundary,
  output logic                    frame_start
);

  localparam logic [DWELL_W-1:0] c_DWELL_LAST = DWELL_W'(DWELL - 1);
  localparam logic [ROW_W-1:0]   c_ROW_LAST   = ROW_W'(ROWS - 1);

  logic [DWELL_W-1:0] r_dwell;
  logic [ROW_W-1:0]   r_row;
  logic               w_row_end;
  logic               w_row_last;

  assign w_row_end  = (r_dwell == c_DWELL_LAST);
  assign w_row_last = (r_row == c_ROW_LAST);

  // Dwell counter wraps each row; row index wraps each frame; cleared when not running.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dwell <= '0;
      r_row   <= '0;
    end else if (!run) begin
      r_dwell <= '0;
      r_row   <= '0;
    end else if (w_row_end) begin
      r_dwell <= '0;
      r_row   <= w_row_last ? '0 : r_row + 1'b1;
    end else begin
      r_dwell <= r_dwell + 1'b1;
    end
  end

  assign dwell_cnt   = r_dwell;
  assign row_idx     = r_row;
  assign boundary    = run && w_row_end && w_row_last;
  // Qualified by the state, not by enable, so the first cycle of a frame
  // is flagged even if enable is dropping on that same cycle.
  assign frame_start = scanning && (r_row == '0) && (r_dwell == '0);

endmodule

`default_nettype wire

// File: rtl/led_matrix_scanner.sv
//------------------------------------------------------------------------------
// Module      : led_matrix_scanner
// Description : Multiplexed LED-matrix driver. Scans a ROWS x COLS frame one
//               row at a time with a per-row dwell of DWELL cycles, global
//               PWM brightness and a double-buffered frame input. New frames
//               are swapped in only at frame boundaries (or on scan start).
//               Optional macro SCREEN_BLANK_EN: forces the outputs dark for
//               the last BLANK_CYCLES cycles of every row (anti-ghosting).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module led_matrix_scanner
  import screen_pkg::*;
#(
  parameter int ROWS       = 8,
  parameter int COLS       = 16,
  parameter int DWELL      = 1024,
  parameter int BRIGHT_W   = 4,
  parameter int ACTIVE_LOW = 1
) (
  input  wire logic                clk,
  input  wire logic                rst,
  input  wire logic                enable,
  input  wire logic [BRIGHT_W-1:0] brightness,
  led_matrix_scanner_if.slave      frame_if,
  output logic [ROWS-1:0]          rows,
  output logic [COLS-1:0]          columns,
  output logic                     frame_start
);

  localparam int ROW_W   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int DWELL_W = $clog2(DWELL);

  localparam logic [DWELL_W-1:0] c_SLOT_LEN = DWELL_W'(DWELL >> BRIGHT_W);
  localparam logic [ROWS-1:0]    c_ROWS_OFF = {ROWS{inactive_level(ACTIVE_LOW)}};
  localparam logic [COLS-1:0]    c_COLS_OFF = {COLS{inactive_level(ACTIVE_LOW)}};

  // ---------------------------------------------------------------------------
  // Scan state machine
  // ---------------------------------------------------------------------------
  scan_state_t r_state;
  scan_state_t w_state_next;
  logic        w_enter;
  logic        w_scanning;
  logic        w_run;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state: enable starts scanning, any cycle without enable stops it.
  always_comb begin
    w_state_next = r_state;
    w_enter      = 1'b0;
    case (r_state)
      IDLE: begin
        if (enable) begin
          w_state_next = SCAN;
          w_enter      = 1'b1;
        end
      end
      SCAN: begin
        if (!enable) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  assign w_scanning = (r_state == SCAN);
  // Counters advance only while scanning continues; this also clears them on
  // the edge that leaves SCAN so IDLE always sees row 0, cycle 0.
  assign w_run      = w_scanning && enable;

  // ---------------------------------------------------------------------------
  // Row / dwell timing
  // ---------------------------------------------------------------------------
  logic [DWELL_W-1:0] w_dwell;
  logic [ROW_W-1:0]   w_row;
  logic               w_boundary;

  scan_timer #(
    .ROWS    (ROWS),
    .DWELL   (DWELL),
    .ROW_W   (ROW_W),
    .DWELL_W (DWELL_W)
  ) u_timer (
    .clk         (clk),
    .rst         (rst),
    .scanning    (w_scanning),
    .run         (w_run),
    .dwell_cnt   (w_dwell),
    .row_idx     (w_row),
    .boundary    (w_boundary),
    .frame_start (frame_start)
  );

  // ---------------------------------------------------------------------------
  // Double buffer and handshake
  // ---------------------------------------------------------------------------
  logic [ROWS*COLS-1:0] r_pending;
  logic [ROWS*COLS-1:0] r_active;
  logic                 r_pending_full;
  logic                 r_ready;
  logic                 w_accept;
  logic                 w_swap;
  logic                 w_pending_full_next;

  assign w_accept = frame_if.frame_valid && r_ready;
  // A swap needs a full pending buffer, which holds ready low, so an accept
  // and a swap can never land on the same edge.
  assign w_swap   = r_pending_full && (w_enter || w_boundary);

  assign w_pending_full_next = w_accept ? 1'b1 :
                               w_swap   ? 1'b0 : r_pending_full;

  // Pending capture on accept, promotion to active at frame start/boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending      <= '0;
      r_active       <= '0;
      r_pending_full <= 1'b0;
      r_ready        <= 1'b1;
    end else begin
      if (w_accept) begin
        r_pending <= frame_if.frame_data;
      end
      if (w_swap) begin
        r_active <= r_pending;
      end
      r_pending_full <= w_pending_full_next;
      r_ready        <= !w_pending_full_next;
    end
  end

  assign frame_if.frame_ready = r_ready;

  // ---------------------------------------------------------------------------
  // PWM brightness
  // ---------------------------------------------------------------------------
  logic [BRIGHT_W-1:0] r_bright;
  logic [BRIGHT_W-1:0] w_bright_eff;
  logic [DWELL_W-1:0]  w_thresh;
  logic                w_pwm_on;
  logic                w_guard;
  logic                w_lit;

  // Brightness is sampled once per row so a change never tears a row.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bright <= '0;
    end else if (w_run && (w_dwell == '0)) begin
      r_bright <= brightness;
    end
  end

  // On the sampling cycle itself the fresh value applies.
  assign w_bright_eff = (w_dwell == '0) ? brightness : r_bright;

  // slot < level  <=>  dwell < level * slot_len, since slot = floor(dwell/slot_len).
  assign w_thresh = DWELL_W'(w_bright_eff) * c_SLOT_LEN;
  assign w_pwm_on = (&w_bright_eff) || (w_dwell < w_thresh);

`ifdef SCREEN_BLANK_EN
  localparam logic [DWELL_W-1:0] c_GUARD_START = DWELL_W'(DWELL - BLANK_CYCLES);
  assign w_guard = (w_dwell >= c_GUARD_START);
`else
  assign w_guard = 1'b0;
`endif

  assign w_lit = w_run && w_pwm_on && !w_guard;

  // ---------------------------------------------------------------------------
  // Row/column drive
  // ---------------------------------------------------------------------------
  logic [COLS-1:0] w_slice [ROWS];
  logic [ROWS-1:0] w_onehot;
  logic [ROWS-1:0] r_rows;
  logic [COLS-1:0] r_cols;

  // Row 0 occupies the most significant slice of the frame word.
  for (genvar r = 0; r < ROWS; r++) begin : g_slice
    assign w_slice[r] = r_active[(ROWS-r)*COLS-1 -: COLS];
  end

  assign w_onehot = ROWS'(1) << w_row;

  // Registered pin drive; XOR with the idle level applies the polarity.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rows <= c_ROWS_OFF;
      r_cols <= c_COLS_OFF;
    end else if (w_lit) begin
      r_rows <= w_onehot ^ c_ROWS_OFF;
      r_cols <= w_slice[w_row] ^ c_COLS_OFF;
    end else begin
      r_rows <= c_ROWS_OFF;
      r_cols <= c_COLS_OFF;
    end
  end

  assign rows    = r_rows;
  assign columns = r_cols;

endmodule

`default_nettype wire

// File: tb/tb_led_matrix_scanner.sv
//------------------------------------------------------------------------------
// Module      : tb_led_matrix_scanner
// Description : Self-checking bench for led_matrix_scanner with a 4x4 matrix,
//               DWELL = 16, BRIGHT_W = 2, active-low drive. Honours
//               SCREEN_BLANK_EN when the design is built with it.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_led_matrix_scanner;

  localparam int ROWS     = 4;
  localparam int COLS     = 4;
  localparam int DWELL    = 16;
  localparam int BRIGHT_W = 2;

`ifdef SCREEN_BLANK_EN
  localparam bit BLK = 1'b1;
`else
  localparam bit BLK = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                enable = 1'b0;
  logic [BRIGHT_W-1:0] brightness = '0;
  logic [ROWS-1:0]     rows;
  logic [COLS-1:0]     columns;
  logic                frame_start;

  led_matrix_scanner_if #(.ROWS(ROWS), .COLS(COLS)) fif ();

  led_matrix_scanner #(
    .ROWS       (ROWS),
    .COLS       (COLS),
    .DWELL      (DWELL),
    .BRIGHT_W   (BRIGHT_W),
    .ACTIVE_LOW (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .brightness  (brightness),
    .frame_if    (fif),
    .rows        (rows),
    .columns     (columns),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Cycle k after a frame_start shows row (k-1)/16, dwell (k-1)%16.
  typedef struct {
    int         ph;
    int         cyc;
    logic [3:0] r;
    logic [3:0] c;
    logic       fs;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [3:0] bl(input logic [3:0] v);
    return BLK ? 4'hF : v;
  endfunction

  task automatic wait_fs(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (frame_start) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("frame_start_timeout", 16'd0, 16'd1);
  endtask

  task automatic run_phase(input int ph, input logic [BRIGHT_W-1:0] b);
    bit ok;
    int maxc;
    maxc = 0;
    brightness = b;
    foreach (tbl[i]) if (tbl[i].ph == ph && tbl[i].cyc > maxc) maxc = tbl[i].cyc;
    wait_fs(ok);
    if (!ok) return;
    for (int k = 0; k <= maxc; k++) begin
      if (k > 0) @(negedge clk);
      foreach (tbl[i]) begin
        if (tbl[i].ph == ph && tbl[i].cyc == k) begin
          check($sformatf("p%0d_c%0d_rows", ph, k), 16'(rows), 16'(tbl[i].r));
          check($sformatf("p%0d_c%0d_cols", ph, k), 16'(columns), 16'(tbl[i].c));
          check($sformatf("p%0d_c%0d_fs", ph, k), 16'(frame_start), 16'(tbl[i].fs));
        end
      end
    end
  endtask

  initial begin
    bit ok;
    fif.frame_data  = '0;
    fif.frame_valid = 1'b0;

    // Phase 0: frame 8421 at full brightness.
    tbl.push_back('{0,  0, 4'hF,      4'hF,      1'b1});
    tbl.push_back('{0,  1, 4'hE,      4'h7,      1'b0});
    tbl.push_back('{0,  8, 4'hE,      4'h7,      1'b0});
    tbl.push_back('{0, 15, bl(4'hE),  bl(4'h7),  1'b0});
    tbl.push_back('{0, 16, bl(4'hE),  bl(4'h7),  1'b0});
    tbl.push_back('{0, 17, 4'hD,      4'hB,      1'b0});
    tbl.push_back('{0, 33, 4'hB,      4'hD,      1'b0});
    tbl.push_back('{0, 40, 4'hB,      4'hD,      1'b0});
    tbl.push_back('{0, 49, 4'h7,      4'hE,      1'b0});
    tbl.push_back('{0, 63, bl(4'h7),  bl(4'hE),  1'b0});
    tbl.push_back('{0, 64, bl(4'h7),  bl(4'hE),  1'b1});
    // Phase 1: brightness 1 -> lit for dwell 0..3 only.
    tbl.push_back('{1,  1, 4'hE, 4'h7, 1'b0});
    tbl.push_back('{1,  4, 4'hE, 4'h7, 1'b0});
    tbl.push_back('{1,  5, 4'hF, 4'hF, 1'b0});
    tbl.push_back('{1, 16, 4'hF, 4'hF, 1'b0});
    tbl.push_back('{1, 17, 4'hD, 4'hB, 1'b0});
    tbl.push_back('{1, 20, 4'hD, 4'hB, 1'b0});
    tbl.push_back('{1, 21, 4'hF, 4'hF, 1'b0});
    tbl.push_back('{1, 52, 4'h7, 4'hE, 1'b0});
    tbl.push_back('{1, 53, 4'hF, 4'hF, 1'b0});

    // Asynchronous reset with no clock edge yet.
    #1 rst = 1'b1;
    #1;
    check("reset_rows",  16'(rows),            16'hF);
    check("reset_cols",  16'(columns),         16'hF);
    check("reset_ready", 16'(fif.frame_ready), 16'd1);
    check("reset_fs",    16'(frame_start),     16'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Load frame A while idle.
    @(negedge clk);
    fif.frame_data  = 16'h8421;
    fif.frame_valid = 1'b1;
    @(negedge clk);
    fif.frame_valid = 1'b0;
    check("ready_after_load", 16'(fif.frame_ready), 16'd0);

    enable = 1'b1;
    run_phase(0, 2'd3);
    run_phase(1, 2'd1);

    // Double buffer: load B mid-frame, offer C while not ready.
    brightness = 2'd3;
    wait_fs(ok);
    repeat (10) @(negedge clk);
    fif.frame_data  = 16'h1248;
    fif.frame_valid = 1'b1;
    @(negedge clk);
    check("db_ready_low", 16'(fif.frame_ready), 16'd0);
    fif.frame_data  = 16'hFFFF;
    repeat (20) @(negedge clk);
    check("db_ready_still_low", 16'(fif.frame_ready), 16'd0);
    fif.frame_valid = 1'b0;
    repeat (18) @(negedge clk);
    check("db_A_row3_rows", 16'(rows),    16'h7);
    check("db_A_row3_cols", 16'(columns), 16'hE);
    repeat (14) @(negedge clk);
    check("db_ready_pre_swap", 16'(fif.frame_ready), 16'd0);
    @(negedge clk);
    check("db_fs",              16'(frame_start),     16'd1);
    check("db_ready_post_swap", 16'(fif.frame_ready), 16'd1);
    @(negedge clk);
    check("db_B_row0_rows", 16'(rows),    16'hE);
    check("db_B_row0_cols", 16'(columns), 16'hE);
    repeat (16) @(negedge clk);
    check("db_B_row1_rows", 16'(rows),    16'hD);
    check("db_B_row1_cols", 16'(columns), 16'hD);
    repeat (32) @(negedge clk);
    check("db_B_row3_rows", 16'(rows),    16'h7);
    check("db_B_row3_cols", 16'(columns), 16'h7);
    wait_fs(ok);
    @(negedge clk);
    check("db_C_rejected_cols", 16'(columns), 16'hE);

    // Enable dropped in row 2, then restart.
    wait_fs(ok);
    repeat (40) @(negedge clk);
    check("en_row2_rows", 16'(rows),    16'hB);
    check("en_row2_cols", 16'(columns), 16'hB);
    enable = 1'b0;
    @(negedge clk);
    check("en_off_rows", 16'(rows),    16'hF);
    check("en_off_cols", 16'(columns), 16'hF);
    repeat (3) @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    check("en_restart_fs",   16'(frame_start), 16'd1);
    check("en_restart_dark", 16'(rows),        16'hF);
    @(negedge clk);
    check("en_restart_rows", 16'(rows),    16'hE);
    check("en_restart_cols", 16'(columns), 16'hE);

    // Reset mid-scan acts without a clock edge.
    #2 rst = 1'b1;
    #1;
    check("async_rst_rows", 16'(rows),        16'hF);
    check("async_rst_cols", 16'(columns),     16'hF);
    check("async_rst_fs",   16'(frame_start), 16'd0);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
